stack_unit: RTL and testbench

- Hardware LIFO operand stack for the stack-machine datapath.
- Driven directly by the multicycle controller's push, pop and tos strobes.
- Its registered top-of-stack output feeds the A/B operand latches (ldA, ldB).
- Its write data comes from the MtoS mux: memory data or ALU result.

---
 rtl/stack_unit_if.sv | 16 +
 rtl/stack_unit.sv | 78 +++++++
 tb/tb_stack_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/stack_unit_if.sv
// stack_unit_if: controller-to-stack bundle.
// master (controller) drives push/pop/tos/din; slave (stack) drives dout/count/empty/full/overflow/underflow.
interface stack_unit_if #(parameter int WIDTH = 8, parameter int PTR_W = 3);
  logic             push;
  logic             pop;
  logic             tos;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [PTR_W:0]   count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;
  modport master (output push, pop, tos, din, input dout, count, empty, full, overflow, underflow);
  modport slave  (input push, pop, tos, din, output dout, count, empty, full, overflow, underflow);
endinterface

// File: rtl/stack_unit.sv
// stack_unit: LIFO operand stack with registered top-of-stack read and sticky error flags.
// Ports: clk, rst (sync active-high), bus (slave modport: push/pop/tos/din in; dout/count/empty/full/overflow/underflow out).
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input logic         clk,
  input logic         rst,
  stack_unit_if.slave bus
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             wr_en;
  logic [PTR_W-1:0] wr_addr, top_idx;
  logic             nonempty, is_full;
  assign nonempty = count_q != '0;
  assign is_full  = count_q == (PTR_W+1)'(DEPTH);
  assign top_idx  = PTR_W'(count_q - 1'b1);
  always_comb begin
    dout_d  = dout_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    wr_addr = count_q[PTR_W-1:0];
    if (bus.push && bus.pop) begin
      wr_en = 1'b1;
      if (nonempty) begin
        // replace top: old top is read out while the new value overwrites it
        dout_d  = mem_q[top_idx];
        wr_addr = top_idx;
      end else begin
        wr_addr = '0;
        count_d = (PTR_W+1)'(1);
        unf_d   = 1'b1;
      end
    end else if (bus.pop) begin
      if (nonempty) begin
        dout_d  = mem_q[top_idx];
        count_d = count_q - 1'b1;
      end else unf_d = 1'b1;
    end else if (bus.push) begin
      if (!is_full) begin
        wr_en   = 1'b1;
        count_d = count_q + 1'b1;
      end else ovf_d = 1'b1;
    end else if (bus.tos) begin
      if (nonempty) dout_d = mem_q[top_idx];
      else unf_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  // storage is never cleared; writes are suppressed during reset
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_addr] <= bus.din;
  end
  assign bus.dout      = dout_q;
  assign bus.count     = count_q;
  assign bus.empty     = count_q == '0;
  assign bus.full      = is_full;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: directed scenarios plus random traffic checked against a queue-based stack model.
module tb_stack_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  logic [7:0] dm = 8'h00;
  logic ov = 1'b0, un = 1'b0;
  stack_unit_if #(.WIDTH(8), .PTR_W(3)) bus ();
  stack_unit #(.WIDTH(8), .DEPTH(8), .PTR_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic op(input logic r, input logic p, input logic po, input logic t, input logic [7:0] d);
    rst = r; bus.push = p; bus.pop = po; bus.tos = t; bus.din = d;
    @(posedge clk);
    if (r) begin
      q.delete(); dm = 8'h00; ov = 1'b0; un = 1'b0;
    end else if (p && po) begin
      if (q.size() > 0) begin dm = q[q.size()-1]; q[q.size()-1] = d; end
      else begin q.push_back(d); un = 1'b1; end
    end else if (po) begin
      if (q.size() > 0) dm = q.pop_back(); else un = 1'b1;
    end else if (p) begin
      if (q.size() < 8) q.push_back(d); else ov = 1'b1;
    end else if (t) begin
      if (q.size() > 0) dm = q[q.size()-1]; else un = 1'b1;
    end
    #1;
    check("dout", bus.dout, dm);
    check("count", bus.count, q.size());
    check("empty", bus.empty, q.size() == 0);
    check("full", bus.full, q.size() == 8);
    check("overflow", bus.overflow, ov);
    check("underflow", bus.underflow, un);
    rst = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.tos = 1'b0;
  endtask
  initial begin
    bus.push = 1'b0; bus.pop = 1'b0; bus.tos = 1'b0; bus.din = 8'h00;
    op(1, 0, 0, 0, 0);
    op(1, 0, 0, 0, 0);
    // push three then tos
    op(0, 1, 0, 0, 8'h11); op(0, 1, 0, 0, 8'h22); op(0, 1, 0, 0, 8'h33);
    op(0, 0, 0, 1, 0);
    check("tp1_tos", bus.dout, 8'h33);
    check("tp1_count", bus.count, 3);
    // pop, pop, push, tos
    op(0, 0, 1, 0, 0);
    check("tp2_pop1", bus.dout, 8'h33);
    op(0, 0, 1, 0, 0);
    check("tp2_pop2", bus.dout, 8'h22);
    op(0, 1, 0, 0, 8'h55); op(0, 0, 0, 1, 0);
    check("tp2_tos", bus.dout, 8'h55);
    check("tp2_count", bus.count, 2);
    // fill past full then drain
    op(1, 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) op(0, 1, 0, 0, 8'(i));
    check("tp3_full", bus.full, 1);
    check("tp3_ovf", bus.overflow, 1);
    for (int i = 8; i >= 1; i--) begin
      op(0, 0, 1, 0, 0);
      check("tp3_drain", bus.dout, i);
    end
    check("tp3_empty", bus.empty, 1);
    check("tp3_ovf_sticky", bus.overflow, 1);
    // underflow and push&pop on empty
    op(1, 0, 0, 0, 0);
    op(0, 0, 1, 0, 0);
    check("tp4_unf", bus.underflow, 1);
    check("tp4_dout_hold", bus.dout, 8'h00);
    op(0, 1, 1, 0, 8'hAA);
    check("tp4_count", bus.count, 1);
    op(0, 0, 1, 0, 0);
    check("tp4_pop", bus.dout, 8'hAA);
    // replace top
    op(1, 0, 0, 0, 0);
    op(0, 1, 0, 0, 8'h11); op(0, 1, 0, 0, 8'h22);
    op(0, 1, 1, 0, 8'h99);
    check("tp5_repl", bus.dout, 8'h22);
    check("tp5_count", bus.count, 2);
    op(0, 0, 1, 0, 0);
    check("tp5_pop1", bus.dout, 8'h99);
    op(0, 0, 1, 0, 0);
    check("tp5_pop2", bus.dout, 8'h11);
    // reset with both flags set at count 5, concurrent push ignored
    op(0, 0, 1, 0, 0);
    for (int i = 0; i < 9; i++) op(0, 1, 0, 0, 8'(8'hC0 + i));
    for (int i = 0; i < 3; i++) op(0, 0, 1, 0, 0);
    check("tp6_pre_count", bus.count, 5);
    check("tp6_pre_flags", {bus.overflow, bus.underflow}, 2'b11);
    op(1, 1, 0, 0, 8'hEE);
    check("tp6_rst_count", bus.count, 0);
    check("tp6_rst_dout", bus.dout, 0);
    check("tp6_rst_flags", {bus.overflow, bus.underflow}, 2'b00);
    check("tp6_rst_empty", bus.empty, 1);
    op(0, 1, 0, 0, 8'h7E); op(0, 0, 0, 1, 0);
    check("tp6_tos", bus.dout, 8'h7E);
    // random traffic, including push with tos and pop with tos
    for (int n = 0; n < 3000; n++) begin
      int unsigned k;
      k = $urandom_range(0, 99);
      op(k == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, 8'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
